// File: rtl/scan_bit_fifo_pkg.sv
// Shared constants and width helper for the scannable bit FIFO.
// Widths are derived from the generic parameters via clog2_f.
package scan_bit_fifo_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 15;
    localparam int DEF_DEPTH = 128;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_bit_ring.sv
// Bit-addressed storage ring: wrapped multi-bit write, wrapped window read,
// and the storage segment of the scan chain (mem[DEPTH-1] in, mem[0] out).
module scan_bit_ring
    import scan_bit_fifo_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = clog2_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             shift_in,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [IN_W-1:0]  wr_data,
    input  logic [PW-1:0]    rd_ptr,
    output logic [OUT_W-1:0] rd_data,
    output logic             shift_out
);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;

    // DEPTH is a power of two, so PW-bit pointer arithmetic wraps for free.
    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d = {shift_in, mem_q[DEPTH-1:1]};
        end else if (wr_en) begin
            for (int i = 0; i < IN_W; i++) begin
                mem_d[wr_ptr + PW'(i)] = wr_data[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < OUT_W; i++) begin
            rd_data[i] = mem_q[rd_ptr + PW'(i)];
        end
    end

    assign shift_out = mem_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/scan_bit_fifo.sv
// Scannable bit-granular FIFO: IN_W-bit pushes, 1..OUT_W-bit replies in
// arrival order. Count, pointers and storage form one serial scan chain.
module scan_bit_fifo
    import scan_bit_fifo_pkg::*;
#(
    parameter  int IN_W  = DEF_IN_W,
    parameter  int OUT_W = DEF_OUT_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int LW    = clog2_f(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushin,
    input  logic [IN_W-1:0]  datain,
    output logic             full,
    input  logic             reqin,
    input  logic [LW-1:0]    reqlen,
    output logic             pushout,
    output logic [LW-1:0]    lenout,
    output logic [OUT_W-1:0] dataout,
    input  logic             scanIn,
    input  logic             scanEnable,
    output logic             scanOut
);

    localparam int PW = clog2_f(DEPTH);
    localparam int CW = clog2_f(DEPTH + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wrptr_q, wrptr_d;
    logic [PW-1:0]    rdptr_q, rdptr_d;
    logic             pushout_q, pushout_d;
    logic [LW-1:0]    lenout_q, lenout_d;
    logic [OUT_W-1:0] dataout_q, dataout_d;

    logic             push_ok;
    logic             req_ok;
    logic [LW-1:0]    clamp_len;
    logic [LW-1:0]    n_len;
    logic [OUT_W-1:0] ring_rd_data;
    logic             ring_out;

    // Handshake: a push is taken whenever full is low (no other ready);
    // pushout is a one-cycle valid with no ready, lenout/dataout hold after it.
    assign full    = count_q > CW'(DEPTH - IN_W);
    assign push_ok = pushin && !full && !scanEnable;
    assign req_ok  = reqin && !scanEnable && (reqlen != '0);

    always_comb begin
        clamp_len = (reqlen > LW'(OUT_W)) ? LW'(OUT_W) : reqlen;
        n_len     = (CW'(clamp_len) > count_q) ? LW'(count_q) : clamp_len;
        if (!req_ok) begin
            n_len = '0;
        end
    end

    always_comb begin
        count_d   = count_q;
        wrptr_d   = wrptr_q;
        rdptr_d   = rdptr_q;
        pushout_d = 1'b0;
        lenout_d  = lenout_q;
        dataout_d = dataout_q;
        if (scanEnable) begin
            // Chain head: scanIn -> count MSB .. LSB -> wrptr -> rdptr -> mem.
            count_d = {scanIn, count_q[CW-1:1]};
            wrptr_d = {count_q[0], wrptr_q[PW-1:1]};
            rdptr_d = {wrptr_q[0], rdptr_q[PW-1:1]};
        end else begin
            if (n_len != '0) begin
                pushout_d = 1'b1;
                lenout_d  = n_len;
                for (int i = 0; i < OUT_W; i++) begin
                    dataout_d[i] = (LW'(i) < n_len) ? ring_rd_data[i] : 1'b0;
                end
                rdptr_d = rdptr_q + PW'(n_len);
            end
            if (push_ok) begin
                wrptr_d = wrptr_q + PW'(IN_W);
            end
            count_d = count_q + CW'(push_ok ? IN_W : 0) - CW'(n_len);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wrptr_q   <= '0;
            rdptr_q   <= '0;
            pushout_q <= 1'b0;
            lenout_q  <= '0;
            dataout_q <= '0;
        end else begin
            count_q   <= count_d;
            wrptr_q   <= wrptr_d;
            rdptr_q   <= rdptr_d;
            pushout_q <= pushout_d;
            lenout_q  <= lenout_d;
            dataout_q <= dataout_d;
        end
    end

    scan_bit_ring #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (scanEnable),
        .shift_in  (rdptr_q[0]),
        .wr_en     (push_ok),
        .wr_ptr    (wrptr_q),
        .wr_data   (datain),
        .rd_ptr    (rdptr_q),
        .rd_data   (ring_rd_data),
        .shift_out (ring_out)
    );

    assign pushout = pushout_q;
    assign lenout  = lenout_q;
    assign dataout = dataout_q;
    assign scanOut = ring_out;

endmodule

// File: tb/tb_scan_bit_fifo.sv
// Bench for scan_bit_fifo: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a bit-array reference model.
module tb_scan_bit_fifo;

    localparam int IN_W  = 32;
    localparam int OUT_W = 15;
    localparam int DEPTH = 128;
    localparam int LW    = 4;
    localparam int CHAIN = 150;

    logic             clk = 1'b0;
    logic             rst;
    logic             pushin;
    logic [IN_W-1:0]  datain;
    logic             full;
    logic             reqin;
    logic [LW-1:0]    reqlen;
    logic             pushout;
    logic [LW-1:0]    lenout;
    logic [OUT_W-1:0] dataout;
    logic             scanIn;
    logic             scanEnable;
    logic             scanOut;

    scan_bit_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .pushin     (pushin),
        .datain     (datain),
        .full       (full),
        .reqin      (reqin),
        .reqlen     (reqlen),
        .pushout    (pushout),
        .lenout     (lenout),
        .dataout    (dataout),
        .scanIn     (scanIn),
        .scanEnable (scanEnable),
        .scanOut    (scanOut)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m[DEPTH];
    int   cnt = 0, rd = 0, wr = 0;
    bit   exp_pushout = 0;
    int   exp_len = 0;
    logic [OUT_W-1:0] exp_data = '0;
    logic [LW+OUT_W-1:0] exp_q[$];

    task automatic model_step();
        bit ch[CHAIN];
        int n;
        bit do_push;
        if (rst) begin
            foreach (m[j]) m[j] = 0;
            cnt = 0; rd = 0; wr = 0;
            exp_pushout = 0; exp_len = 0; exp_data = '0;
            exp_q.delete();
            return;
        end
        if (scanEnable) begin
            for (int j = 0; j < 8; j++) ch[j] = bit'((cnt >> (7 - j)) & 1);
            for (int j = 0; j < 7; j++) ch[8 + j] = bit'((wr >> (6 - j)) & 1);
            for (int j = 0; j < 7; j++) ch[15 + j] = bit'((rd >> (6 - j)) & 1);
            for (int k = 0; k < DEPTH; k++) ch[22 + k] = m[DEPTH - 1 - k];
            for (int j = CHAIN - 1; j > 0; j--) ch[j] = ch[j - 1];
            ch[0] = scanIn;
            cnt = 0; wr = 0; rd = 0;
            for (int j = 0; j < 8; j++) cnt = cnt * 2 + int'(ch[j]);
            for (int j = 0; j < 7; j++) wr = wr * 2 + int'(ch[8 + j]);
            for (int j = 0; j < 7; j++) rd = rd * 2 + int'(ch[15 + j]);
            for (int k = 0; k < DEPTH; k++) m[DEPTH - 1 - k] = ch[22 + k];
            exp_pushout = 0;
            return;
        end
        do_push = pushin && !(cnt > DEPTH - IN_W);
        n = 0;
        if (reqin && reqlen != 0) begin
            n = int'(reqlen);
            if (n > OUT_W) n = OUT_W;
            if (n > cnt) n = cnt;
        end
        if (n > 0) begin
            exp_pushout = 1;
            exp_len = n;
            exp_data = '0;
            for (int i = 0; i < n; i++) exp_data[i] = m[(rd + i) % DEPTH];
            rd = (rd + n) % DEPTH;
            exp_q.push_back({LW'(n), exp_data});
        end else begin
            exp_pushout = 0;
        end
        if (do_push) begin
            for (int i = 0; i < IN_W; i++) m[(wr + i) % DEPTH] = datain[i];
            wr = (wr + IN_W) % DEPTH;
        end
        cnt = (cnt + (do_push ? IN_W : 0) - n) & 255;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- scoreboard / compare ----------------
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            logic [LW+OUT_W-1:0] item;
            check("pushout", 32'(pushout), 32'(exp_pushout));
            if (exp_pushout && exp_q.size() != 0) begin
                item = exp_q.pop_front();
                check("lenout", 32'(lenout), 32'(item[LW+OUT_W-1:OUT_W]));
                check("dataout", 32'(dataout), 32'(item[OUT_W-1:0]));
            end else begin
                check("lenout_hold", 32'(lenout), 32'(exp_len));
                check("dataout_hold", 32'(dataout), 32'(exp_data));
            end
            check("full", 32'(full), 32'(cnt > DEPTH - IN_W));
            check("scanOut", 32'(scanOut), 32'(m[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pushin = 0; datain = '0; reqin = 0; reqlen = '0;
        scanEnable = 0; scanIn = 0;
    endtask

    task automatic drive(input bit p, input logic [IN_W-1:0] d, input bit r, input int len);
        pushin = p; datain = d; reqin = r; reqlen = LW'(len);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pushout"}, 32'(pushout), 32'd0);
        check({tag, "_lenout"}, 32'(lenout), 32'd0);
        check({tag, "_dataout"}, 32'(dataout), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_scanOut"}, 32'(scanOut), 32'd0);
    endtask

    bit pat[CHAIN];

    initial begin
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;
        check_en = 1;

        // field extraction
        drive(1, 32'h0000ABCD, 0, 0);
        drive(0, '0, 1, 4);
        check("f4_pushout", 32'(pushout), 32'd1);
        check("f4_len", 32'(lenout), 32'd4);
        check("f4_data", 32'(dataout), 32'h000D);
        drive(0, '0, 1, 15);
        check("f15_len", 32'(lenout), 32'd15);
        check("f15_data", 32'(dataout), 32'h0ABC);

        // partial reply, then empty
        drive(0, '0, 1, 15);
        check("part_len", 32'(lenout), 32'd13);
        check("part_data", 32'(dataout), 32'h0000);
        drive(0, '0, 1, 3);
        check("empty_pushout", 32'(pushout), 32'd0);

        // full, dropped push, drain across the wrap point
        for (int w = 0; w < 4; w++) drive(1, $urandom, 0, 0);
        check("full_set", 32'(full), 32'd1);
        drive(1, 32'hFFFF_FFFF, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, '0, 1, 15);
            check("drain_len", 32'(lenout), 32'd15);
        end
        drive(0, '0, 1, 15);
        check("drain_tail_len", 32'(lenout), 32'd8);
        drive(0, '0, 1, 1);
        check("drop_pushout", 32'(pushout), 32'd0);

        // simultaneous push and request at count 0
        drive(1, 32'hFFFF_FFFF, 1, 5);
        check("sim_pushout", 32'(pushout), 32'd0);
        drive(0, '0, 1, 5);
        check("sim_len", 32'(lenout), 32'd5);
        check("sim_data", 32'(dataout), 32'h001F);

        // reset asserted mid-cycle
        drive(1, 32'h1234_5678, 0, 0);
        #3 rst = 1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 0;

        // scan round trip
        drive(1, $urandom, 0, 0);
        drive(1, $urandom, 1, 7);
        foreach (pat[k]) pat[k] = bit'($urandom_range(0, 1));
        for (int k = 0; k < CHAIN; k++) begin
            scanEnable = 1; scanIn = pat[k];
            drive(1, $urandom, 1, 15);
            check("scan_pushout", 32'(pushout), 32'd0);
        end
        for (int k = 0; k < CHAIN; k++) begin
            check("scan_out_pat", 32'(scanOut), 32'(pat[k]));
            scanEnable = 1; scanIn = 0;
            drive(0, '0, 0, 0);
        end
        for (int k = 0; k < 60; k++) begin
            scanEnable = 1; scanIn = pat[k];
            drive(0, '0, 0, 0);
        end
        #3 rst = 1;
        #1;
        check("scanrst_scanOut", 32'(scanOut), 32'd0);
        check("scanrst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < CHAIN; k++) begin
            scanEnable = 1; scanIn = 0;
            drive(0, '0, 0, 0);
        end
        idle();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            drive(bit'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15));
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_bit_fifo.md
# scan_bit_fifo

Parametrised, scannable bit-granular FIFO. Accepts IN_W-bit words, returns requested bit-fields of 1..OUT_W bits in arrival order, with a registered length tag. All internal state (storage, pointers, occupancy) forms one serial scan chain for test load and unload. Second-generation bit packer: adds generic widths and depth, a full flag with backpressure, partial-length replies, and a defined scan order.

## Interface
- IN_W, 32, push word width.
- OUT_W, 15, maximum reply width in bits.
- DEPTH, 128, storage in bits. Power of two, ≥ IN_W, ≥ OUT_W.
- LW = $clog2(OUT_W+1), PW = $clog2(DEPTH), CW = $clog2(DEPTH+1) (derived localparams).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pushin  in  1  push strobe.
- datain  in  IN_W  push word. Bit 0 is oldest.
- full  out  1  combinational, `count > DEPTH-IN_W`.
- reqin  in  1  request strobe.
- reqlen  in  LW  requested bit count.
- pushout  out  1  registered reply valid.
- lenout  out  LW  registered reply length.
- dataout  out  OUT_W  registered reply bits. Bit 0 is oldest. Bits ≥ lenout are 0.
- scanIn  in  1  scan serial input.
- scanEnable  in  1  scan shift mode.
- scanOut  out  1  scan serial output, = mem[0] state bit.

## Operation
- **Storage:** bit ring mem[DEPTH-1:0], with wrptr (PW bits), rdptr (PW bits) and count (CW bits).
- **Reset:** mem, pointers, count, pushout, lenout and dataout all go to 0. full=0, scanOut=0.
- **Push:** accepted when `pushin && !full && !scanEnable`.
  - datain[i] is written to mem[(wrptr+i) mod DEPTH].
  - wrptr += IN_W (wraps mod DEPTH); count += IN_W.
  - A push while full is dropped silently.
- **Request:** served when `reqin && !scanEnable && reqlen != 0`.
  - Effective length n = min(reqlen, OUT_W, count). reqlen > OUT_W clamps to OUT_W.
  - If n = 0, there is no reply.
  - Otherwise, next cycle: pushout=1, lenout=n, dataout[i] = mem[(rdptr+i) mod DEPTH] for i<n, and 0 above.
  - rdptr += n; count -= n.
- **Simultaneous push and request:** the request sees the pre-push count and bits. full uses the registered count and ignores a same-cycle pop. Final count = count + IN_W·push − n.
- **Idle cycles:** pushout=0. lenout and dataout hold their last values.
- **Scan:**
  - Chain order from scanIn to scanOut: count[CW-1:0] (MSB first), wrptr[PW-1:0], rdptr[PW-1:0], mem[DEPTH-1:0].
  - Each scanEnable cycle shifts by one: scanIn enters count MSB, and mem[0] drops out as scanOut.
  - Chain length L = CW+2·PW+DEPTH (150 at defaults).
  - While scanEnable=1: push and request are ignored and the pushout register loads 0. lenout, dataout and full are not in the chain.
  - After scanEnable falls, normal operation resumes from the shifted-in state. Inconsistent pointer/count values are used as loaded, with no checking.
- **Reset mid-operation or mid-scan:** immediate clear. Partially shifted chain contents are lost.

## Timing
- Push at edge k: bits are readable by a request sampled at edge k+1.
- Request sampled at edge k: reply is valid in the cycle after edge k. Latency is 1, and one request per cycle is supported.
- full updates combinationally from count after each edge.
- scanOut changes one cycle after each shifting edge. The first scanned-out bit is the pre-scan mem[0], visible before the first shift.

## Structure
- Package scan_bit_fifo_pkg holds the LW/PW/CW clog2 helper function and the default parameter constants.
- One sub-module, scan_bit_ring: mem plus the wrapped indexed write/read and the mem segment of the shift path.
- The top level holds count/pointers, request clamp, output registers and chain stitching.

## Test plan
All scenarios use default parameters.
- **Reset:** assert rst mid-cycle → all outputs 0 immediately, full=0.
- **Field extraction:**
  - Push 0x0000ABCD, then req 4 → pushout, lenout=4, dataout=0x000D.
  - Next req 15 → lenout=15, dataout=0x0ABC.
- **Partial reply:** after the above (count=13), req 15 → lenout=13, dataout=0. A further req 3 → no pushout.
- **Full and drop:**
  - Push 4 words → count=128, full=1.
  - A 5th push is ignored.
  - req 15 ×8 drains in order, crossing the wrap point. Check the bit sequence against a model.
- **Simultaneous push and request:** with count=0, push 0xFFFFFFFF and req 5 in the same cycle → no reply. Next-cycle req 5 → dataout=0x001F.
- **Scan round trip:**
  - Shift in 150 bits of a known pattern with pushin=reqin=1 held → no pushout and no state change beyond the shift.
  - Shift 150 more → scanOut reproduces the pattern in order.
  - Reassert rst mid-shift → chain cleared.
